// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory-op encodings, FSM states and byte-lane helpers
package mem_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } mem_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   function automatic logic op_is_load(input mem_op_e op);
      case (op)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return a[0];
         OP_LW, OP_SW:         return (a != 2'b00);
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] op_size(input mem_op_e op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic [3:0] op_wstrb(input mem_op_e op, input logic [1:0] a);
      case (op)
         OP_SB:   return 4'b0001 << a;
         OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Stores replicate the datum over every lane it may land in; loads send nothing
   function automatic logic [31:0] op_wdata(input mem_op_e op, input logic [31:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         OP_SW:   return d;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - request/address_ok/data_ok data-bus bundle
interface mem_access_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W/8-1:0]   data_wstrb;
   logic [DATA_W-1:0]     data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_W-1:0]     data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_access_load_ext.sv
// rtl/mem_access_load_ext.sv - load lane select and sign/zero extension
module load_ext
   import mem_pkg::*;
(
   input  mem_op_e     op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half-word out of the returned word
   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extend to 32 bits; non-load ops yield zero so stores never leak bus data
   always_comb begin
      result = 32'd0;
      case (op)
         OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  result = {24'd0, byte_sel};
         OP_LH:   result = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  result = {16'd0, half_sel};
         OP_LW:   result = rdata;
         default: result = 32'd0;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS memory-stage data-bus access unit
module mem_access
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [3:0]        mem_op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush_i,
   input  logic              stall_i,
   mem_access_if.master      bus,
   output logic [DATA_W-1:0] rdata_o,
   output logic              done_o,
   output logic              stall_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [ADDR_W-1:0] badvaddr_o
);
   mem_state_e        state;
   mem_op_e           op_in;
   mem_op_e           cap_op;
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_wr;
   logic [1:0]        cap_size;
   logic [3:0]        cap_wstrb;
   logic [DATA_W-1:0] cap_wdata;
   logic [DATA_W-1:0] hold_data;
   logic [DATA_W-1:0] ext_data;
   logic              op_live;
   logic              misaligned;
   logic              issue;
   logic              fault;
   logic              resp_done;

   // Unused encodings behave as a bubble
   assign op_in      = (mem_op_i > 4'd8) ? OP_NONE : mem_op_e'(mem_op_i);
   assign op_live    = valid_i & (op_in != OP_NONE);
   assign misaligned = op_misaligned(op_in, addr_i[1:0]);
   assign issue      = (state == ST_IDLE) & op_live & ~misaligned & ~flush_i;
   assign fault      = (state == ST_IDLE) & op_live & misaligned & ~flush_i;
   assign resp_done  = (state == ST_WAIT) & bus.data_data_ok & ~stall_i & ~flush_i;

   load_ext u_load_ext (
      .op     (cap_op),
      .addr   (cap_addr[1:0]),
      .rdata  (bus.data_rdata),
      .result (ext_data)
   );

   // Request fields come live from EX/MEM in the issue cycle, then from the captured copy
   always_comb begin
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_size  = SZ_BYTE;
      bus.data_addr  = '0;
      bus.data_wstrb = '0;
      bus.data_wdata = '0;
      if (issue) begin
         bus.data_req   = 1'b1;
         bus.data_wr    = op_is_store(op_in);
         bus.data_size  = op_size(op_in);
         bus.data_addr  = addr_i;
         bus.data_wstrb = op_wstrb(op_in, addr_i[1:0]);
         bus.data_wdata = op_wdata(op_in, wdata_i);
      end else if (state == ST_REQ) begin
         bus.data_req   = 1'b1;
         bus.data_wr    = cap_wr;
         bus.data_size  = cap_size;
         bus.data_addr  = cap_addr;
         bus.data_wstrb = cap_wstrb;
         bus.data_wdata = cap_wdata;
      end
   end

   // Pipeline-facing results: completion, stall, load data and address exceptions
   always_comb begin
      rdata_o    = '0;
      done_o     = 1'b0;
      stall_o    = 1'b0;
      adel_o     = 1'b0;
      ades_o     = 1'b0;
      badvaddr_o = '0;
      case (state)
         ST_IDLE: begin
            stall_o = issue;
            done_o  = fault;
            adel_o  = fault & op_is_load(op_in);
            ades_o  = fault & ~op_is_load(op_in);
            if (fault) badvaddr_o = addr_i;
         end
         ST_REQ: begin
            stall_o = ~flush_i;
         end
         ST_WAIT: begin
            done_o  = resp_done;
            stall_o = ~flush_i & ~resp_done;
            if (resp_done) rdata_o = ext_data;
         end
         ST_HOLD: begin
            done_o  = 1'b1;
            rdata_o = hold_data;
         end
         ST_DRAIN: begin
            stall_o = op_live;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

   // Access sequencing: one outstanding access, flush withdraws or drains it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cap_op    <= OP_NONE;
         cap_addr  <= '0;
         cap_wr    <= 1'b0;
         cap_size  <= SZ_BYTE;
         cap_wstrb <= '0;
         cap_wdata <= '0;
         hold_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  cap_op    <= op_in;
                  cap_addr  <= addr_i;
                  cap_wr    <= op_is_store(op_in);
                  cap_size  <= op_size(op_in);
                  cap_wstrb <= op_wstrb(op_in, addr_i[1:0]);
                  cap_wdata <= op_wdata(op_in, wdata_i);
                  state     <= bus.data_addr_ok ? ST_WAIT : ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus.data_addr_ok) state <= flush_i ? ST_DRAIN : ST_WAIT;
               else if (flush_i)     state <= ST_IDLE;
            end
            ST_WAIT: begin
               if (flush_i) begin
                  state <= bus.data_data_ok ? ST_IDLE : ST_DRAIN;
               end else if (bus.data_data_ok) begin
                  if (stall_i) begin
                     hold_data <= ext_data;
                     state     <= ST_HOLD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               if (~stall_i | flush_i) state <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (bus.data_data_ok) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [3:0]  mem_op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        flush_i;
   logic        stall_i;
   logic [31:0] rdata_o;
   logic        done_o;
   logic        stall_o;
   logic        adel_o;
   logic        ades_o;
   logic [31:0] badvaddr_o;

   int checks   = 0;
   int failures = 0;

   mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .mem_op_i   (mem_op_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .flush_i    (flush_i),
      .stall_i    (stall_i),
      .bus        (bus),
      .rdata_o    (rdata_o),
      .done_o     (done_o),
      .stall_o    (stall_o),
      .adel_o     (adel_o),
      .ades_o     (ades_o),
      .badvaddr_o (badvaddr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        flush;
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  strb;
      logic [31:0] wd;
      logic        adel;
      logic        ades;
      logic        done;
      logic        stall;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [159:0] pk(input logic req, wr, input logic [1:0] size,
                                       input logic [3:0] strb, input logic [31:0] addr, wd,
                                       input logic adel, ades, done, stall,
                                       input logic [31:0] badv, rdata);
      return {20'd0, req, wr, size, strb, addr, wd, adel, ades, done, stall, badv, rdata};
   endfunction

   function automatic logic [159:0] obs_all();
      return pk(bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr,
                bus.data_wdata, adel_o, ades_o, done_o, stall_o, badvaddr_o, rdata_o);
   endfunction

   function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] addr, wdata,
                                input logic flush, req, wr, input logic [1:0] size,
                                input logic [3:0] strb, input logic [31:0] wd,
                                input logic adel, ades, done, stall);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.flush = flush;
      v.req = req; v.wr = wr; v.size = size; v.strb = strb; v.wd = wd;
      v.adel = adel; v.ades = ades; v.done = done; v.stall = stall;
      return v;
   endfunction

   // Reference model: byte count, signedness and lane arithmetic from the op's meaning
   function automatic int m_bytes(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         default:              return 4;
      endcase
   endfunction

   function automatic logic m_is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic m_signed(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input int off, input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] mask;
      int nb;
      nb   = m_bytes(op);
      v    = rd >> (8 * off);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v    = v & mask;
      if (m_signed(op) && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] d);
      if (nb == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
      if (nb == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      mem_op_e     ops[8];
      logic [159:0] act, exp;
      int          hs;
      int          adv;
      logic [31:0] rd, got_r;
      logic        got_s;

      ops[0] = OP_LB; ops[1] = OP_LBU; ops[2] = OP_LH; ops[3] = OP_LHU;
      ops[4] = OP_LW; ops[5] = OP_SB;  ops[6] = OP_SH; ops[7] = OP_SW;

      //            op       addr          wdata          fl req wr sz strb     wd             adel ades done stall
      vt[0]  = mkv(OP_SH,   32'h2002,     32'h1234_ABCD, 0, 1, 1, 1, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 1);
      vt[1]  = mkv(OP_SB,   32'h1001,     32'h0000_00A5, 0, 1, 1, 0, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 1);
      vt[2]  = mkv(OP_SB,   32'h1003,     32'h1234_5678, 0, 1, 1, 0, 4'b1000, 32'h7878_7878, 0, 0, 0, 1);
      vt[3]  = mkv(OP_SH,   32'h2000,     32'hDEAD_BEEF, 0, 1, 1, 1, 4'b0011, 32'hBEEF_BEEF, 0, 0, 0, 1);
      vt[4]  = mkv(OP_SW,   32'h4000,     32'hCAFE_F00D, 0, 1, 1, 2, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 1);
      vt[5]  = mkv(OP_LW,   32'h3001,     32'hFFFF_FFFF, 0, 0, 0, 0, 4'b0000, 32'h0,         1, 0, 1, 0);
      vt[6]  = mkv(OP_SW,   32'h3002,     32'h5555_5555, 0, 0, 0, 0, 4'b0000, 32'h0,         0, 1, 1, 0);
      vt[7]  = mkv(OP_LH,   32'h0005,     32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         1, 0, 1, 0);
      vt[8]  = mkv(OP_SH,   32'h0007,     32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         0, 1, 1, 0);
      vt[9]  = mkv(OP_LB,   32'h0003,     32'hFFFF_FFFF, 0, 1, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 1);
      vt[10] = mkv(OP_LHU,  32'h0002,     32'h0,         0, 1, 0, 1, 4'b0000, 32'h0,         0, 0, 0, 1);
      vt[11] = mkv(OP_NONE, 32'h0001,     32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 0);
      vt[12] = mkv(OP_LW,   32'h0004,     32'h0,         1, 0, 0, 0, 4'b0000, 32'h0,         0, 0, 0, 0);

      rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
      flush_i = 1'b0; stall_i = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", obs_all(), 160'd0);
      rst = 1'b0;
      tick();

      // Issue-cycle decode table; each issued op is withdrawn by a flush in REQ
      for (int i = 0; i < 13; i++) begin
         valid_i = 1'b1; mem_op_i = vt[i].op; addr_i = vt[i].addr;
         wdata_i = vt[i].wdata; flush_i = vt[i].flush;
         #1;
         exp = pk(vt[i].req, vt[i].wr, vt[i].size, vt[i].strb, vt[i].req ? vt[i].addr : 32'd0,
                  vt[i].wr ? vt[i].wd : 32'd0, vt[i].adel, vt[i].ades, vt[i].done, vt[i].stall,
                  (vt[i].adel | vt[i].ades) ? vt[i].addr : 32'd0, 32'd0);
         act = pk(bus.data_req, bus.data_req & bus.data_wr,
                  bus.data_req ? bus.data_size : 2'd0, bus.data_req ? bus.data_wstrb : 4'd0,
                  bus.data_req ? bus.data_addr : 32'd0,
                  (bus.data_req & bus.data_wr) ? bus.data_wdata : 32'd0,
                  adel_o, ades_o, done_o, stall_o, badvaddr_o, rdata_o);
         chk($sformatf("vec%0d", i), act, exp);
         tick();
         valid_i = 1'b0; flush_i = 1'b1;
         tick();
         flush_i = 1'b0;
      end

      // Best case LB: accepted in the issue cycle, data the next cycle
      valid_i = 1'b1; mem_op_i = OP_LB; addr_i = 32'h1003; bus.data_addr_ok = 1'b1;
      #1;
      chk("lb_c1_req_stall_done", {bus.data_req, stall_o, done_o}, 3'b110);
      tick();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF_FF7F;
      #1;
      chk("lb_c2_done_stall_rdata", {done_o, stall_o, rdata_o}, {1'b1, 1'b0, 32'hFFFF_FF80});
      tick();
      valid_i = 1'b0; bus.data_data_ok = 1'b0;
      #1;
      chk("lb_after_idle", {bus.data_req, stall_o, done_o}, 3'b000);
      tick();

      // addr_ok three cycles late, then data_ok under a two-cycle stall
      hs = 0;
      valid_i = 1'b1; mem_op_i = OP_LW; addr_i = 32'h5000;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         bus.data_addr_ok = (k == 3);
         #1;
         chk($sformatf("hold_req_c%0d", k), {bus.data_req, stall_o, bus.data_size, bus.data_addr},
             {1'b1, 1'b1, 2'd2, 32'h5000});
         if (bus.data_req && bus.data_addr_ok) hs++;
      end
      tick();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1122_3344; stall_i = 1'b1;
      #1;
      if (bus.data_req && bus.data_addr_ok) hs++;
      tick();
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'hAAAA_AAAA; stall_i = 1'b1;
      #1;
      chk("hold_stalled", {bus.data_req, done_o, rdata_o}, {1'b0, 1'b1, 32'h1122_3344});
      if (bus.data_req && bus.data_addr_ok) hs++;
      tick();
      stall_i = 1'b0;
      #1;
      chk("hold_release", {bus.data_req, done_o, rdata_o}, {1'b0, 1'b1, 32'h1122_3344});
      chk("hold_handshakes", hs, 1);
      tick();
      valid_i = 1'b0;
      tick();

      // Flush in WAIT, late response drained, LHU waits for the drain
      valid_i = 1'b1; mem_op_i = OP_LW; addr_i = 32'h6000; bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0; valid_i = 1'b0; flush_i = 1'b1;
      tick();
      flush_i = 1'b0; valid_i = 1'b1; mem_op_i = OP_LHU; addr_i = 32'h7002;
      #1;
      chk("drain_no_req_stall", {bus.data_req, stall_o}, 2'b01);
      tick();
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_0000;
      #1;
      chk("drain_discard", {bus.data_req, done_o, rdata_o}, {1'b0, 1'b0, 32'd0});
      tick();
      bus.data_data_ok = 1'b0; bus.data_addr_ok = 1'b1;
      #1;
      chk("lhu_issue", {bus.data_req, bus.data_size, bus.data_addr}, {1'b1, 2'd1, 32'h7002});
      tick();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h8765_1234;
      #1;
      chk("lhu_result", {done_o, stall_o, rdata_o}, {1'b1, 1'b0, 32'h0000_8765});
      tick();
      valid_i = 1'b0; bus.data_data_ok = 1'b0;
      tick();

      // Asynchronous reset while a request is pending
      valid_i = 1'b1; mem_op_i = OP_SW; addr_i = 32'h8000; wdata_i = 32'h0000_0001;
      tick();
      valid_i = 1'b0;
      #1;
      chk("rst_pre_req", bus.data_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", obs_all(), 160'd0);
      tick();
      rst = 1'b0;
      tick();
      #1;
      chk("rst_idle_outputs", obs_all(), 160'd0);

      // Randomized transactions against the reference model
      for (int t = 0; t < 150; t++) begin
         logic [3:0]  op;
         logic [31:0] a, d;
         int la, ld, hsn, nb, off;
         logic is_ld;
         op  = ops[$urandom_range(0, 7)];
         a   = $urandom; d = $urandom;
         la  = $urandom_range(0, 3); ld = $urandom_range(1, 3); hsn = $urandom_range(0, 2);
         nb  = m_bytes(op); is_ld = m_is_load(op); off = int'(a[1:0]);
         valid_i = 1'b1; mem_op_i = op; addr_i = a; wdata_i = d;
         if ((off % nb) != 0) begin
            #1;
            chk($sformatf("rnd%0d_fault", t),
                {bus.data_req, adel_o, ades_o, done_o, stall_o, badvaddr_o},
                {1'b0, is_ld, ~is_ld, 1'b1, 1'b0, a});
            tick();
            valid_i = 1'b0;
            tick();
         end else begin
            hs = 0; adv = -1; rd = 32'd0; got_r = 32'd0; got_s = 1'b1;
            for (int c = 0; c < 20 && adv < 0; c++) begin
               if (c > 0) tick();
               bus.data_addr_ok = (c == la);
               bus.data_data_ok = (c == la + ld);
               stall_i          = (c >= la + ld) && (c < la + ld + hsn);
               bus.data_rdata   = $urandom;
               #1;
               if (c == la + ld) rd = bus.data_rdata;
               if (bus.data_req) begin
                  chk($sformatf("rnd%0d_bus", t),
                      {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr,
                       is_ld ? 32'd0 : bus.data_wdata},
                      {~is_ld, (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2,
                       is_ld ? 4'd0 : 4'(((1 << nb) - 1) << off), a,
                       is_ld ? 32'd0 : m_wdata(nb, d)});
                  if (bus.data_addr_ok) hs++;
               end
               if (c < la + ld) chk($sformatf("rnd%0d_stall_c%0d", t, c), stall_o, 1'b1);
               if (done_o && !stall_i) begin
                  adv = c; got_r = rdata_o; got_s = stall_o;
               end
            end
            chk($sformatf("rnd%0d_advance_cycle", t), adv, la + ld + hsn);
            chk($sformatf("rnd%0d_handshakes", t), hs, 1);
            chk($sformatf("rnd%0d_stall_at_done", t), got_s, 1'b0);
            if (is_ld) chk($sformatf("rnd%0d_rdata", t), got_r, m_load(op, off, rd));
            tick();
            valid_i = 1'b0; stall_i = 1'b0;
            bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
